// File: rtl/pipe_addsub_n_if.sv
// Purpose: operand/result bundle for pipe_addsub_n, as valid/ready on both sides.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready carry the flow control; see pipe_addsub_n.
// Signals: in_valid/in_ready, op[1:0], a/b[N-1:0], cin (producer side);
//          out_valid/out_ready, result[N-1:0], flag_n/z/c/v (consumer side).
// master = producer+consumer environment, slave = the adder pipeline.
interface pipe_addsub_n_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         flag_n;
  logic         flag_z;
  logic         flag_c;
  logic         flag_v;

  modport master (
    output in_valid, op, a, b, cin, out_ready,
    input  in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v
  );

  modport slave (
    input  in_valid, op, a, b, cin, out_ready,
    output in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v
  );
endinterface

// File: rtl/pipe_addsub_n.sv
// Purpose: pipelined N-bit ADD/ADC/SUB/SBC, CHUNK bits per stage, with NZCV flags.
// Latency: STAGES = N/CHUNK cycles from accept to out_valid, plus one per stall cycle.
// Backpressure: whole pipe freezes while out_valid & ~out_ready; in_ready = ~stall.
// Ports: clk, rst (async, active-high); bus (slave modport of pipe_addsub_n_if):
//   in_valid/in_ready/op/a/b/cin in, out_valid/out_ready/result/flag_n/z/c/v out.
// N must be a multiple of CHUNK and at least 2.
module pipe_addsub_n #(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic           clk,
  input  logic           rst,
  pipe_addsub_n_if.slave bus
);
  localparam int STAGES = N / CHUNK;
  localparam int LAST   = STAGES - 1;

  logic         stall;
  logic         adv;
  logic         c0;
  logic [N-1:0] b_eff;

  // Per-stage state. x carries the finished low result chunks merged with the
  // still-pending upper chunks of a (skew and deskew share one register);
  // y carries the conditioned b operand; cy is the chunk carry-out.
  logic         vld_q [STAGES];
  logic [N-1:0] x_q   [STAGES];
  logic [N-1:0] y_q   [STAGES];
  logic         cy_q  [STAGES];

  logic         vld_d [STAGES];
  logic [N-1:0] x_d   [STAGES];
  logic [N-1:0] y_d   [STAGES];
  logic         cy_d  [STAGES];

  logic [N-1:0] x_in  [STAGES];
  logic [N-1:0] y_in  [STAGES];
  logic         c_in  [STAGES];
  logic         v_in  [STAGES];
  logic [CHUNK:0] sum [STAGES];

  logic fn_q, fz_q, fv_q;
  logic fn_d, fz_d, fv_d;
  logic c_msb;

  assign stall        = bus.out_valid & ~bus.out_ready;
  assign adv          = ~stall;
  assign bus.in_ready = adv;

  // Subtraction is a + ~b + carry; only the carry source differs per op.
  assign b_eff = bus.op[1] ? ~bus.b : bus.b;

  always_comb begin
    case (bus.op)
      2'b00:   c0 = 1'b0;
      2'b01:   c0 = bus.cin;
      2'b10:   c0 = 1'b1;
      default: c0 = bus.cin;
    endcase
  end

  always_comb begin
    x_in[0] = bus.a;
    y_in[0] = b_eff;
    c_in[0] = c0;
    v_in[0] = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      x_in[k] = x_q[k-1];
      y_in[k] = y_q[k-1];
      c_in[k] = cy_q[k-1];
      v_in[k] = vld_q[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      sum[k] = {1'b0, x_in[k][k*CHUNK +: CHUNK]}
             + {1'b0, y_in[k][k*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, c_in[k]};
      x_d[k] = x_in[k];
      x_d[k][k*CHUNK +: CHUNK] = sum[k][CHUNK-1:0];
      y_d[k]   = y_in[k];
      cy_d[k]  = sum[k][CHUNK];
      vld_d[k] = v_in[k];
    end

    // Carry into bit N-1 recovered from the MSB sum bit and its two operand
    // bits; for CHUNK=1 this is exactly the previous stage's carry.
    c_msb = x_d[LAST][N-1] ^ x_in[LAST][N-1] ^ y_in[LAST][N-1];
    fn_d  = x_d[LAST][N-1];
    fz_d  = (x_d[LAST] == '0);
    fv_d  = cy_d[LAST] ^ c_msb;
  end

  // Bubbles advance with don't-care data; only vld_q qualifies the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        x_q[k]   <= '0;
        y_q[k]   <= '0;
        cy_q[k]  <= 1'b0;
      end
      fn_q <= 1'b0;
      fz_q <= 1'b0;
      fv_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= vld_d[k];
        x_q[k]   <= x_d[k];
        y_q[k]   <= y_d[k];
        cy_q[k]  <= cy_d[k];
      end
      fn_q <= fn_d;
      fz_q <= fz_d;
      fv_q <= fv_d;
    end
  end

  assign bus.out_valid = vld_q[LAST];
  assign bus.result    = x_q[LAST];
  assign bus.flag_n    = fn_q;
  assign bus.flag_z    = fz_q;
  assign bus.flag_c    = cy_q[LAST];
  assign bus.flag_v    = fv_q;
endmodule

// File: tb/tb_pipe_addsub_n.sv
// Purpose: self-checking bench for pipe_addsub_n (directed + randomized sweeps).
// Latency: main DUT is N=32/CHUNK=8, so 4 cycles accept-to-output.
// Backpressure: bench drives out_ready patterns and holds inputs until in_ready.
module tb_pipe_addsub_n;
  logic clk = 1'b0;
  logic rst;
  logic sweep_go = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain w-bit modular arithmetic; V from operand/result signs.
  function automatic logic [35:0] model(input int w, input logic [1:0] op,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic cin);
    logic [63:0] mask, aa, bb, full, res;
    logic c0, sa, sb, sr, cf, v, z;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'd0, a} & mask;
    bb   = op[1] ? (~{32'd0, b}) & mask : {32'd0, b} & mask;
    c0   = (op == 2'b00) ? 1'b0 : (op == 2'b10) ? 1'b1 : cin;
    full = aa + bb + {63'd0, c0};
    res  = full & mask;
    cf   = full[w];
    sa   = aa[w-1];
    sb   = bb[w-1];
    sr   = res[w-1];
    v    = (sa == sb) && (sr != sa);
    z    = (res == 64'd0);
    return {res[31:0], sr, z, cf, v};
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] one;
    one = 32'd1;
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return one << (w - 1);
      3:       return (one << (w - 1)) - 32'd1;
      default: return $urandom();
    endcase
  endfunction

  // ---------------- main DUT: N=32, CHUNK=8 ----------------
  pipe_addsub_n_if #(.N(32)) m_if();
  pipe_addsub_n #(.N(32), .CHUNK(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (m_if)
  );

  function automatic logic [3:0] m_nzcv();
    return {m_if.flag_n, m_if.flag_z, m_if.flag_c, m_if.flag_v};
  endfunction

  task automatic run_one(input string tag, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic [31:0] eres, input logic [3:0] enzcv);
    int lat;
    @(negedge clk);
    m_if.op = op; m_if.a = a; m_if.b = b; m_if.cin = cin;
    m_if.in_valid = 1'b1; m_if.out_ready = 1'b1;
    #1;
    chk({tag, "_rdy"}, m_if.in_ready, 1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    m_if.in_valid = 1'b0;
    while (!m_if.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_res"}, m_if.result, eres);
    chk({tag, "_nzcv"}, m_nzcv(), enzcv);
  endtask

  // ---------------- parameter sweep DUTs ----------------
  for (genvar g = 0; g < 3; g++) begin : sw
    localparam int NW = (g == 1) ? 16 : 8;
    localparam int CW = (g == 0) ? 8 : (g == 1) ? 4 : 1;
    logic done = 1'b0;

    pipe_addsub_n_if #(.N(NW)) s_if();
    pipe_addsub_n #(.N(NW), .CHUNK(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (s_if)
    );

    initial begin
      logic [35:0] q[$];
      logic [35:0] e;
      logic [31:0] ra, rb;
      int   sent, got, cyc;
      logic acc;
      s_if.in_valid = 1'b0; s_if.op = 2'b00; s_if.a = '0; s_if.b = '0;
      s_if.cin = 1'b0; s_if.out_ready = 1'b0;
      sent = 0; got = 0; cyc = 0; acc = 1'b0;
      wait (sweep_go);
      while (got < 1000 && cyc < 20000) begin
        @(negedge clk);
        if (!s_if.in_valid || acc) begin
          if (sent < 1000) begin
            ra = pick(NW);
            rb = pick(NW);
            s_if.in_valid = ($urandom_range(0, 3) != 0);
            s_if.a   = ra[NW-1:0];
            s_if.b   = rb[NW-1:0];
            s_if.op  = 2'($urandom_range(0, 3));
            s_if.cin = 1'($urandom_range(0, 1));
          end else begin
            s_if.in_valid = 1'b0;
          end
        end
        s_if.out_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (s_if.out_valid && s_if.out_ready) begin
          e = (q.size() > 0) ? q.pop_front() : 36'hF_FFFF_FFFF;
          chk($sformatf("sw%0d_res_nzcv", g),
              {32'(s_if.result), s_if.flag_n, s_if.flag_z, s_if.flag_c, s_if.flag_v}, e);
          got++;
        end
        acc = s_if.in_valid && s_if.in_ready;
        if (acc) begin
          q.push_back(model(NW, s_if.op, 32'(s_if.a), 32'(s_if.b), s_if.cin));
          sent++;
        end
        cyc++;
      end
      chk($sformatf("sw%0d_count", g), got, 1000);
      done = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int   sent, got, cyc, stale, t;
    logic prev_stall;
    logic [31:0] prev_res;

    rst = 1'b1;
    m_if.in_valid = 1'b0; m_if.op = 2'b00; m_if.a = '0; m_if.b = '0;
    m_if.cin = 1'b0; m_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vld",  m_if.out_valid, 0);
    chk("rst_res",  m_if.result, 0);
    chk("rst_nzcv", m_nzcv(), 0);
    rst = 1'b0;
    #1;
    chk("rst_rdy", m_if.in_ready, 1);

    run_one("add_wrap", 2'b00, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0,         4'b0110);
    run_one("sub_ovf",  2'b10, 32'h8000_0000, 32'h1, 1'b0, 32'h7FFF_FFFF, 4'b0011);
    run_one("sub_neg",  2'b10, 32'd5,         32'd7, 1'b0, 32'hFFFF_FFFE, 4'b1000);
    run_one("adc_ovf",  2'b01, 32'h7FFF_FFFF, 32'h0, 1'b1, 32'h8000_0000, 4'b1001);
    run_one("sbc",      2'b11, 32'd10,        32'd3, 1'b0, 32'd6,         4'b0010);

    // Streaming: 8 back-to-back ADDs, consumer stalls on cycles 5..7.
    sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev_res = '0;
    while (got < 8 && cyc < 60) begin
      @(negedge clk);
      m_if.out_ready = !(cyc >= 5 && cyc <= 7);
      if (sent < 8) begin
        m_if.in_valid = 1'b1; m_if.op = 2'b00; m_if.cin = 1'b0;
        m_if.a = 32'(sent); m_if.b = 32'(sent);
      end else begin
        m_if.in_valid = 1'b0;
      end
      #1;
      chk("strm_rdy", m_if.in_ready, !(m_if.out_valid && !m_if.out_ready));
      if (prev_stall) chk("strm_hold", m_if.result, prev_res);
      if (m_if.out_valid && m_if.out_ready) begin
        chk("strm_res", m_if.result, 2 * got);
        got++;
      end
      if (m_if.in_valid && m_if.in_ready) sent++;
      prev_stall = m_if.out_valid && !m_if.out_ready;
      prev_res   = m_if.result;
      cyc++;
    end
    chk("strm_cnt", got, 8);
    @(negedge clk);
    #1;
    chk("strm_extra", m_if.out_valid, 0);

    // Reset with the pipe full: first bundle at the output, three behind it.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      m_if.in_valid = 1'b1; m_if.out_ready = 1'b1; m_if.op = 2'b00; m_if.cin = 1'b0;
      m_if.a = (i == 0) ? 32'hFFFF_FFFF : $urandom();
      m_if.b = (i == 0) ? 32'h1 : $urandom();
    end
    @(posedge clk);
    #2;
    chk("mid_pre_vld",  m_if.out_valid, 1);
    chk("mid_pre_nzcv", m_nzcv(), 4'b0110);
    rst = 1'b1;
    #1;
    chk("mid_vld",  m_if.out_valid, 0);
    chk("mid_nzcv", m_nzcv(), 0);
    chk("mid_res",  m_if.result, 0);
    m_if.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (m_if.out_valid) stale++;
    end
    chk("mid_stale", stale, 0);
    run_one("post_rst", 2'b00, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 4'b0000);

    // Randomized parameter sweep on the three small configurations.
    sweep_go = 1'b1;
    t = 0;
    while (t < 60000 && !(sw[0].done && sw[1].done && sw[2].done)) begin
      @(posedge clk);
      t++;
    end
    chk("sweep_done", {sw[0].done, sw[1].done, sw[2].done}, 3'b111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_addsub_n.md
Name: pipe_addsub_n

Overview:
- Parametrised, pipelined successor to the team's N-bit ripple adder.
- Splits an N-bit add/subtract into N/CHUNK carry-chained stages, one chunk per clock, with operand skew and result deskew registers.
- Supports four ARM-style ops (ADD/ADC/SUB/SBC) and produces NZCV flags.
- Uses a valid/ready handshake with full-pipeline backpressure; sits between the hybrid ALU issue logic and writeback.

Parameters:
- N, 32, operand/result width; must be a multiple of CHUNK, and N >= 2.
- CHUNK, 8, bits added per pipeline stage. STAGES = N/CHUNK (derived localparam, >= 1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand bundle valid
- in_ready  output  1  block accepts a bundle this cycle
- op  input  2  00 ADD a+b; 01 ADC a+b+cin; 10 SUB a+~b+1; 11 SBC a+~b+cin
- a  input  N  operand A
- b  input  N  operand B
- cin  input  1  carry-in; used only by ADC/SBC
- out_valid  output  1  result bundle valid
- out_ready  input  1  consumer accepts result
- result  output  N  sum/difference
- flag_n  output  1  result[N-1]
- flag_z  output  1  result == 0
- flag_c  output  1  carry out of bit N-1 (SUB/SBC: 1 = no borrow)
- flag_v  output  1  signed overflow = carry into bit N-1 XOR carry out of bit N-1

Behaviour:
- Reset (async assert, sync release):
  - All stage valid bits clear; out_valid=0; result=0; all flags 0.
  - No transaction survives a reset asserted mid-operation.
  - in_ready=1 on the first cycle after release.
- Stall: stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - While stall=1, every pipeline register (data, carries, valids) holds its value.
- Accept: a bundle is accepted on a clk edge with in_valid & in_ready.
  - At acceptance, b is conditioned: b_eff = op[1] ? ~b : b.
  - Carry-in: c0 = 0 for ADD, cin for ADC, 1 for SUB, cin for SBC.
- Stage k (0..STAGES-1):
  - Computes {carry_k, sum_k} = a_chunk_k + b_eff_chunk_k + carry_(k-1), with carry_(-1) = c0.
  - Registers sum_k and carry_k.
  - Upper operand chunks travel in skew registers until their stage.
  - Lower result chunks travel in deskew registers so that all chunks are aligned at the output.
- Stage k also registers, for the MSB chunk only, the carry into bit N-1 (for V). When CHUNK=1, this is carry_(STAGES-2).
- Latency: an accepted bundle appears with out_valid=1 exactly STAGES cycles later, absent stalls. Each stall cycle adds one cycle.
- Throughput: one bundle per cycle while out_ready=1. There are no bubbles between back-to-back accepts.
- Output: result and flags are registered and stable while out_valid & ~out_ready. They change only after a handshake or when a new bundle advances.
- Empty stages: a stage with valid=0 may carry don't-care data, but out_valid must never assert for it. out_valid=0 has no consumer effect.
- Simultaneous events: out handshake and in accept in the same cycle is legal and is the steady-state case.
- in_valid while stalled is not accepted. The producer holds a, b, op and cin until in_ready.
- Wrap-around: arithmetic is modulo 2^N. The carry out is reported in flag_c, never widened into result.
- STAGES=1 degenerates to a single registered adder with the same handshake and latency 1.

Test Plan:
- ADD, N=32, CHUNK=8: a=0xFFFF_FFFF, b=0x0000_0001 -> after 4 cycles: result=0, Z=1, C=1, V=0, N=0 (carry ripples through all 4 stages).
- SUB: a=0x8000_0000, b=1 -> result=0x7FFF_FFFF, C=1, V=1, N=0, Z=0. SUB: a=5, b=7 -> result=0xFFFF_FFFE, C=0, N=1, V=0.
- ADC/SBC: ADC a=0x7FFF_FFFF, b=0, cin=1 -> 0x8000_0000, V=1, N=1. SBC a=10, b=3, cin=0 -> 6, C=1.
- Streaming with backpressure:
  - Issue 8 back-to-back ADDs (a=i, b=i).
  - Hold out_ready=0 on cycles 5-7.
  - Required: in_ready=0 exactly while out_valid & ~out_ready; outputs 2i arrive in order with none lost or duplicated; held result is stable during the stall.
- Reset mid-flight: assert rst asynchronously with 3 bundles in flight -> out_valid and flags drop immediately; no stale result appears after release; the next accept returns after exactly STAGES cycles.
- Parameter sweep (N=8/CHUNK=8, N=16/CHUNK=4, N=8/CHUNK=1): 1000 random op/a/b/cin compared against a reference model for result and NZCV.
